// File: rtl/ram_arbiter_if.sv
// Signal bundle between the two memory requesters, the arbiter and the RAM port.
// The arbiter connects through the slave modport; requesters/RAM model use master.
interface ram_arbiter_if;
  logic [1:0]  req_ren;
  logic [1:0]  req_wen;
  logic [31:0] req_addr0;
  logic [31:0] req_addr1;
  logic [31:0] req_store0;
  logic [31:0] req_store1;
  logic [1:0]  req_wait;
  logic [31:0] req_load0;
  logic [31:0] req_load1;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        err_ram;
  logic        err_timeout;

  modport slave (
    input  req_ren, req_wen, req_addr0, req_addr1, req_store0, req_store1,
    input  ramload, ramstate,
    output req_wait, req_load0, req_load1,
    output ramREN, ramWEN, ramaddr, ramstore,
    output err_ram, err_timeout
  );

  modport master (
    output req_ren, req_wen, req_addr0, req_addr1, req_store0, req_store1,
    output ramload, ramstate,
    input  req_wait, req_load0, req_load1,
    input  ramREN, ramWEN, ramaddr, ramstore,
    input  err_ram, err_timeout
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM port between two requesters, holding the
// grant until the RAM completes, with a per-access watchdog.
//
// state | meaning
// IDLE  | no grant held; picks the next owner from active requests
// SERVE | grant held by owner_q; RAM driven from the owner's live request
module ram_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input logic           CLK,
  input logic           RST,
  ram_arbiter_if.slave  bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SERVE = 1'b1;

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  logic [0:0] state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic [7:0] wdog_q, wdog_d;
  logic       err_ram_q, err_ram_d;
  logic       err_timeout_q, err_timeout_d;

  logic [1:0]  active;
  logic        serve;
  logic        own_ren, own_wen, own_act;
  logic        rs_access, rs_error, wdog_hit;
  logic        done_data, done;
  logic [1:0]  gnt_vec;
  logic [31:0] load_val;

  assign active    = bus.req_ren | bus.req_wen;
  assign serve     = (state_q == ST_SERVE);
  assign own_ren   = bus.req_ren[owner_q];
  assign own_wen   = bus.req_wen[owner_q];
  assign own_act   = own_ren | own_wen;
  assign rs_access = (bus.ramstate == RS_ACCESS);
  assign rs_error  = (bus.ramstate == RS_ERROR);
  assign wdog_hit  = (wdog_q == WDOG_LAST);

  // A dropped request outranks the watchdog, so a timeout only completes a live request.
  assign done_data = serve & (rs_access | rs_error);
  assign done      = done_data | (serve & own_act & wdog_hit);
  assign gnt_vec   = owner_q ? 2'b10 : 2'b01;

  assign load_val  = (done_data & own_ren & ~own_wen) ? bus.ramload : 32'd0;

  assign bus.req_wait  = active & ~(gnt_vec & {2{done}});
  assign bus.req_load0 = owner_q ? 32'd0 : load_val;
  assign bus.req_load1 = owner_q ? load_val : 32'd0;

  // Write wins when both strobes are raised by the owner.
  assign bus.ramREN   = serve & own_ren & ~own_wen;
  assign bus.ramWEN   = serve & own_wen;
  assign bus.ramaddr  = serve ? (owner_q ? bus.req_addr1 : bus.req_addr0) : 32'd0;
  assign bus.ramstore = serve ? (owner_q ? bus.req_store1 : bus.req_store0) : 32'd0;

  assign bus.err_ram     = err_ram_q;
  assign bus.err_timeout = err_timeout_q;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    wdog_d        = wdog_q;
    err_ram_d     = err_ram_q;
    err_timeout_d = err_timeout_q;

    if (state_q == ST_IDLE) begin
      if (active != 2'b00) begin
        state_d = ST_SERVE;
        wdog_d  = 8'd0;
        owner_d = (active == 2'b11) ? ~last_q : active[1];
      end
    end else begin
      if (rs_access) begin
        last_d  = owner_q;
        state_d = ST_IDLE;
      end else if (rs_error) begin
        err_ram_d = 1'b1;
        last_d    = owner_q;
        state_d   = ST_IDLE;
      end else if (!own_act) begin
        state_d = ST_IDLE;
      end else if (wdog_hit) begin
        err_timeout_d = 1'b1;
        last_d        = owner_q;
        state_d       = ST_IDLE;
      end else begin
        wdog_d = wdog_q + 8'd1;
      end
    end
  end

  // last_q resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      owner_q       <= 1'b0;
      last_q        <= 1'b1;
      wdog_q        <= 8'd0;
      err_ram_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      wdog_q        <= wdog_d;
      err_ram_q     <= err_ram_d;
      err_timeout_q <= err_timeout_d;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: read, contention, write precedence, abort,
// ERROR completion, watchdog timeout and reset in the middle of an access.
module tb_ram_arbiter;

  localparam logic [1:0] RS_FREE   = 2'd0;
  localparam logic [1:0] RS_BUSY   = 2'd1;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  logic CLK = 1'b0;
  logic RST;
  int   n_checks = 0;
  int   n_errors = 0;

  ram_arbiter_if bus ();

  ram_arbiter #(.TIMEOUT(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change just after the falling edge; checks follow a short settle.
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    logic exp_owner;

    RST = 1'b1;
    bus.req_ren    = 2'b00;
    bus.req_wen    = 2'b00;
    bus.req_addr0  = 32'd0;
    bus.req_addr1  = 32'd0;
    bus.req_store0 = 32'd0;
    bus.req_store1 = 32'd0;
    bus.ramload    = 32'd0;
    bus.ramstate   = RS_FREE;
    step();
    step();

    // reset: wait mirrors the active vector, RAM side quiet
    bus.req_ren = 2'b01;
    settle();
    chk("rst_wait", 32'(bus.req_wait), 32'h1);
    step();
    chk("rst_ren", 32'(bus.ramREN), 32'h0);
    chk("rst_addr", bus.ramaddr, 32'h0);
    chk("rst_load0", bus.req_load0, 32'h0);
    chk("rst_errs", 32'({bus.err_ram, bus.err_timeout}), 32'h0);
    bus.req_ren = 2'b00;

    // single read
    RST = 1'b0;
    bus.req_ren   = 2'b01;
    bus.req_addr0 = 32'h40;
    settle();
    chk("rd_idle_ren", 32'(bus.ramREN), 32'h0);
    step();
    chk("rd_grant_ren", 32'(bus.ramREN), 32'h1);
    chk("rd_grant_addr", bus.ramaddr, 32'h40);
    chk("rd_grant_wait", 32'(bus.req_wait), 32'h1);
    bus.ramstate = RS_BUSY;
    step();
    step();
    bus.ramstate = RS_ACCESS;
    bus.ramload  = 32'hDEADBEEF;
    settle();
    chk("rd_done_wait", 32'(bus.req_wait), 32'h0);
    chk("rd_done_load0", bus.req_load0, 32'hDEADBEEF);
    chk("rd_done_load1", bus.req_load1, 32'h0);
    step();
    bus.ramstate = RS_FREE;
    settle();
    chk("rd_after_ren", 32'(bus.ramREN), 32'h0);
    chk("rd_after_wait", 32'(bus.req_wait), 32'h1);
    bus.req_ren = 2'b00;
    step();

    // contention straight after reset
    RST = 1'b1;
    step();
    RST = 1'b0;
    bus.req_ren   = 2'b11;
    bus.req_addr0 = 32'h100;
    bus.req_addr1 = 32'h200;
    for (int k = 0; k < 4; k++) begin
      exp_owner = k[0];
      step();
      chk($sformatf("ct%0d_addr", k), bus.ramaddr, exp_owner ? 32'h200 : 32'h100);
      chk($sformatf("ct%0d_wait", k), 32'(bus.req_wait), 32'h3);
      bus.ramstate = RS_ACCESS;
      bus.ramload  = 32'hA000_0000 + 32'(k);
      settle();
      chk($sformatf("ct%0d_dwait", k), 32'(bus.req_wait), exp_owner ? 32'h1 : 32'h2);
      chk($sformatf("ct%0d_load", k), exp_owner ? bus.req_load1 : bus.req_load0,
          32'hA000_0000 + 32'(k));
      step();
      bus.ramstate = RS_FREE;
      settle();
      chk($sformatf("ct%0d_idle_ren", k), 32'(bus.ramREN), 32'h0);
    end

    // write precedence on requester 1
    bus.req_ren    = 2'b10;
    bus.req_wen    = 2'b10;
    bus.req_addr1  = 32'h300;
    bus.req_store1 = 32'h12345678;
    step();
    chk("wr_wen", 32'(bus.ramWEN), 32'h1);
    chk("wr_ren", 32'(bus.ramREN), 32'h0);
    chk("wr_store", bus.ramstore, 32'h12345678);
    chk("wr_addr", bus.ramaddr, 32'h300);
    bus.ramstate = RS_ACCESS;
    settle();
    chk("wr_done_wait", 32'(bus.req_wait), 32'h0);
    chk("wr_load1", bus.req_load1, 32'h0);
    step();
    bus.ramstate = RS_FREE;
    bus.req_ren  = 2'b00;
    bus.req_wen  = 2'b00;
    step();

    // abort: requester 0 drops mid-SERVE; last stays 1
    bus.req_ren = 2'b01;
    step();
    bus.ramstate = RS_BUSY;
    settle();
    chk("ab_addr", bus.ramaddr, 32'h100);
    step();
    bus.req_ren = 2'b00;
    settle();
    chk("ab_wait", 32'(bus.req_wait), 32'h0);
    chk("ab_ren", 32'(bus.ramREN), 32'h0);
    step();
    chk("ab_errs", 32'({bus.err_ram, bus.err_timeout}), 32'h0);
    bus.ramstate = RS_FREE;
    bus.req_ren  = 2'b11;
    step();
    chk("ab_next_addr", bus.ramaddr, 32'h100);
    chk("ab_next_wait", 32'(bus.req_wait), 32'h3);
    bus.ramstate = RS_ACCESS;
    settle();
    chk("ab_next_dwait", 32'(bus.req_wait), 32'h2);
    step();
    bus.ramstate = RS_FREE;
    bus.req_ren  = 2'b10;

    // ERROR completion on requester 1
    step();
    bus.ramstate = RS_ERROR;
    bus.ramload  = 32'hBAD0BAD0;
    settle();
    chk("er_wait", 32'(bus.req_wait), 32'h0);
    chk("er_load1", bus.req_load1, 32'hBAD0BAD0);
    step();
    bus.ramstate = RS_FREE;
    bus.req_ren  = 2'b00;
    settle();
    chk("er_flag", 32'(bus.err_ram), 32'h1);
    chk("er_tmo_flag", 32'(bus.err_timeout), 32'h0);

    // watchdog: RAM stays BUSY, release at the 8th SERVE cycle
    bus.req_ren  = 2'b01;
    bus.ramstate = RS_BUSY;
    step();
    for (int c = 1; c < 8; c++) begin
      chk($sformatf("to_wait_c%0d", c), 32'(bus.req_wait), 32'h1);
      step();
    end
    chk("to_wait_c8", 32'(bus.req_wait), 32'h0);
    chk("to_flag_pre", 32'(bus.err_timeout), 32'h0);
    step();
    bus.req_ren = 2'b00;
    chk("to_flag", 32'(bus.err_timeout), 32'h1);
    bus.ramstate = RS_FREE;
    bus.req_ren  = 2'b01;
    step();
    bus.ramstate = RS_ACCESS;
    bus.ramload  = 32'h5555AAAA;
    settle();
    chk("to_later_load", bus.req_load0, 32'h5555AAAA);
    step();
    bus.ramstate = RS_FREE;
    bus.req_ren  = 2'b00;
    settle();
    chk("to_sticky", 32'(bus.err_timeout), 32'h1);
    chk("er_sticky", 32'(bus.err_ram), 32'h1);
    step();

    // reset in the middle of an access
    bus.req_ren = 2'b01;
    step();
    chk("mr_ren_pre", 32'(bus.ramREN), 32'h1);
    RST = 1'b1;
    settle();
    chk("mr_ren_hold", 32'(bus.ramREN), 32'h1);
    step();
    chk("mr_ren", 32'(bus.ramREN), 32'h0);
    chk("mr_addr", bus.ramaddr, 32'h0);
    chk("mr_errs", 32'({bus.err_ram, bus.err_timeout}), 32'h0);
    chk("mr_wait", 32'(bus.req_wait), 32'h1);
    RST = 1'b0;
    bus.req_ren = 2'b11;
    step();
    chk("mr_first_addr", bus.ramaddr, 32'h100);
    chk("mr_first_wait", 32'(bus.req_wait), 32'h3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
